// File: rtl/ps2_rx_frontend_if.sv
// Scan code handshake between the PS/2 receiver and its consumer.
interface ps2_rx_frontend_if;
  logic [7:0] SCANCODE;
  logic       SCANCODE_VALID;
  logic       SCANCODE_READY;

  modport master (output SCANCODE, output SCANCODE_VALID, input SCANCODE_READY);
  modport slave  (input SCANCODE, input SCANCODE_VALID, output SCANCODE_READY);
endinterface

// File: rtl/ps2_rx_frontend.sv
// PS/2 keyboard receive front end: pad sync, clock deglitch, frame deserialise, one-entry buffer.
// Optional odd-parity checking is enabled with `define PS2_RX_PARITY_CHECK_EN.
module ps2_rx_frontend #(
  parameter int CLK_HZ     = 40000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 200
) (
  input  logic CLK_40MHZ,
  input  logic RESET_N,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  ps2_rx_frontend_if.master sc,
  output logic FRAME_ERR,
  output logic OVERRUN
);

  localparam int TO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TO_W     = $clog2(TO_LIMIT) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] dly_q, dly_d;
  logic [3:0]            flt_cnt_q, flt_cnt_d;
  logic                  fclk_q, fclk_d, fclk_prev_q, fall_q, fall_d;
  logic [1:0]            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]            sc_q, sc_d;
  logic                  vld_q, vld_d, err_q, err_d, ovr_q, ovr_d;
  logic                  bit_in, par_ok, timeout, frame_ok, frame_bad;

  // Data is delayed by the filter depth so it lines up with the filtered clock edge.
  assign bit_in = dly_q[FILTER_LEN-1];

`ifdef PS2_RX_PARITY_CHECK_EN
  assign par_ok = ^{par_q, shreg_q};
`else
  logic par_unused;
  assign par_unused = par_q;
  assign par_ok     = 1'b1;
`endif

  always_comb begin
    dly_d     = {dly_q[FILTER_LEN-2:0], dat_s2_q};
    fclk_d    = fclk_q;
    flt_cnt_d = '0;
    if (clk_s2_q != fclk_q) begin
      if (flt_cnt_q == 4'(FILTER_LEN - 1)) fclk_d = clk_s2_q;
      else                                 flt_cnt_d = flt_cnt_q + 4'd1;
    end
    fall_d = fclk_prev_q & ~fclk_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    timeout   = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    to_cnt_d  = (state_q == IDLE || fall_q) ? '0 : to_cnt_q + TO_W'(1);
    if (state_q != IDLE && to_cnt_q == TO_W'(TO_LIMIT)) begin
      timeout  = 1'b1;
      state_d  = IDLE;
      to_cnt_d = '0;
    end else if (fall_q) begin
      case (state_q)
        IDLE: if (!bit_in) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shreg_d   = {bit_in, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (bit_in && par_ok) frame_ok  = 1'b1;
          else                  frame_bad = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    sc_d  = sc_q;
    vld_d = vld_q;
    err_d = frame_bad | timeout;
    ovr_d = 1'b0;
    if (frame_ok) begin
      // A stalled consumer keeps its byte; the newcomer is dropped.
      if (vld_q && !sc.SCANCODE_READY) begin
        ovr_d = 1'b1;
      end else begin
        sc_d  = shreg_q;
        vld_d = 1'b1;
      end
    end else if (vld_q && sc.SCANCODE_READY) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_40MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      dly_q       <= '1;
      flt_cnt_q   <= '0;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      sc_q        <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      clk_s1_q    <= PS2_CLK;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= PS2_DATA;
      dat_s2_q    <= dat_s1_q;
      dly_q       <= dly_d;
      flt_cnt_q   <= flt_cnt_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_q;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      sc_q        <= sc_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign sc.SCANCODE       = sc_q;
  assign sc.SCANCODE_VALID = vld_q;
  assign FRAME_ERR         = err_q;
  assign OVERRUN           = ovr_q;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Scoreboard bench for ps2_rx_frontend: directed PS/2 frames, monitor pops expected bytes/events.
`timescale 1ns/1ps
module tb_ps2_rx_frontend;
  localparam int FL    = 8;
  localparam int LIMIT = 8000;
  localparam int H     = 40;   // PS/2 half-period in system cycles
  localparam logic [1:0] EV_ERR = 2'b10;
  localparam logic [1:0] EV_OVR = 2'b01;

  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic frame_err, overrun;
  int   cyc = 0, checks = 0, failures = 0;
  int   vld_rise_cyc = -1, vld_cnt = 0, err_cyc = -1, last_fall = 0;
  logic vld_prev = 1'b0;
  logic [7:0] exp_sc_q[$];
  logic [1:0] exp_ev_q[$];

  ps2_rx_frontend_if sc_if();

  ps2_rx_frontend #(.CLK_HZ(40000000), .FILTER_LEN(FL), .TIMEOUT_US(200)) dut (
    .CLK_40MHZ(clk), .RESET_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_dat),
    .sc(sc_if.master), .FRAME_ERR(frame_err), .OVERRUN(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and every error/overrun pulse.
  always @(negedge clk) begin
    if (sc_if.SCANCODE_VALID && !vld_prev) vld_rise_cyc = cyc;
    if (sc_if.SCANCODE_VALID) vld_cnt++;
    vld_prev = sc_if.SCANCODE_VALID;
    if (sc_if.SCANCODE_VALID && sc_if.SCANCODE_READY) begin
      if (exp_sc_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_byte actual=%0h required=none", sc_if.SCANCODE);
      end else check("scancode", {24'd0, sc_if.SCANCODE}, {24'd0, exp_sc_q.pop_front()});
    end
    if (frame_err || overrun) begin
      err_cyc = cyc;
      if (exp_ev_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_event actual=%0b required=none", {frame_err, overrun});
      end else check("event", {30'd0, frame_err, overrun}, {30'd0, exp_ev_q.pop_front()});
    end
  end

  // bits[0] first on the wire; optional 3-cycle low glitch in the high phase of bit gb.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int gb);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      tick(H / 2);
      if (i == gb) begin
        ps2_clk = 1'b0; tick(3);
        ps2_clk = 1'b1; tick(3);
      end
      tick(H / 2);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    tick(H);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int gb);
    send_bits({1'b1, p, d, 1'b0}, 11, gb);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sc_if.SCANCODE_READY = 1'b1;
    tick(3);
    check("rst_scancode", {24'd0, sc_if.SCANCODE}, 32'h00);
    check("rst_valid", {31'd0, sc_if.SCANCODE_VALID}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // 1: 0x1C, parity 0, latency and single-cycle VALID
    vld_cnt = 0; vld_rise_cyc = -1;
    exp_sc_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, -1);
    check("t1_latency", vld_rise_cyc - last_fall, FL + 4);
    check("t1_valid_cycles", vld_cnt, 1);

    // 2: 0x1C with bad parity bit
`ifdef PS2_RX_PARITY_CHECK_EN
    exp_ev_q.push_back(EV_ERR);
    vld_cnt = 0;
    send_frame(8'h1C, 1'b1, -1);
    check("t2_no_valid", vld_cnt, 0);
`else
    exp_sc_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b1, -1);
`endif

    // 3: stalled consumer, overrun on second frame
    sc_if.SCANCODE_READY = 1'b0;
    exp_sc_q.push_back(8'hF0);
    exp_ev_q.push_back(EV_OVR);
    send_frame(8'hF0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, -1);
    check("t3_held_byte", {24'd0, sc_if.SCANCODE}, 32'hF0);
    check("t3_held_valid", {31'd0, sc_if.SCANCODE_VALID}, 32'd1);
    sc_if.SCANCODE_READY = 1'b1;
    tick(2);
    check("t3_valid_drop", {31'd0, sc_if.SCANCODE_VALID}, 32'd0);

    // 4: stalled frame times out, then a clean frame
    exp_ev_q.push_back(EV_ERR);
    err_cyc = -1;
    send_bits({5'b11111, 6'b010100}, 6, -1);
    for (int i = 0; i < LIMIT + 500 && err_cyc < 0; i++) tick(1);
    if (err_cyc < 0) begin
      checks++; failures++;
      $display("FAIL t4_timeout actual=none required=frame_err");
    end else begin
      // counter clears at the edge consuming the last fall (FL+4), hits LIMIT, flags next cycle
      checks++;
      if (err_cyc - last_fall < LIMIT + FL + 4 || err_cyc - last_fall > LIMIT + FL + 6) begin
        failures++;
        $display("FAIL t4_timeout_delay actual=%0d required=%0d", err_cyc - last_fall, LIMIT + FL + 5);
      end
    end
    exp_sc_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1, -1);

    // 5: short clock glitches in idle and mid-frame
    ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(20);
    vld_cnt = 0;
    exp_sc_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 4);
    check("t5_once", vld_cnt, 1);

    // 6: reset mid-frame, then a clean frame
    send_bits({6'b111111, 5'b10010}, 5, -1);
    rst_n = 1'b0;
    tick(2);
    check("t6_rst_scancode", {24'd0, sc_if.SCANCODE}, 32'h00);
    check("t6_rst_valid", {31'd0, sc_if.SCANCODE_VALID}, 32'd0);
    check("t6_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    tick(5);
    exp_sc_q.push_back(8'h29);
    send_frame(8'h29, 1'b0, -1);

    tick(20);
    check("sb_bytes_left", exp_sc_q.size(), 0);
    check("sb_events_left", exp_ev_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
